pc_fetch_unit: RTL and testbench
================================

// Module: pc_fetch_unit
// PURPOSE
//  Program-counter and fetch-control stage feeding the byte-addressed, registered-read instruction memory.
//  Drives read_instruct_addr and tracks which PC each returned instruction word belongs to.
//  Flags each word valid or bubble for decode.
//  Resolves branch / jump / jr redirects issued by decode; no delay slot, 1-bubble redirect penalty.
// PARAMETERS
//  RESET_PC   32'h0000_0000  PC loaded on reset
//  IMEM_BYTES 256            instruction memory size in bytes; byte addresses >= IMEM_BYTES are out of range
// PORTS
//  clk                 in   1   rising-edge clock
//  rst                 in   1   synchronous, active-high reset
//  stall               in   1   decode cannot accept; hold fetch
//  halt                in   1   stop fetching (sticky until rst)
//  branch_taken        in   1   taken conditional branch for the word at pc_d
//  branch_offset       in   16  branch immediate (word offset, signed)
//  jump_en             in   1   J-type jump for the word at pc_d
//  jump_index          in   26  J-type target index
//  jr_en               in   1   register jump for the word at pc_d
//  jr_target           in   32  register jump byte address
//  read_instruct_addr  out  32  byte address to instruction memory
//  pc_d                out  32  PC of the word the memory presents this cycle
//  pc_plus4_d          out  32  pc_d + 4
//  fetch_valid         out  1   memory output is a real, in-path instruction
//  halted              out  1   unit is in HALTED
//  fault               out  1   misaligned or out-of-range target taken (sticky)
// BEHAVIOUR
//  Reset (rst=1 at edge): state=BOOT, pc=RESET_PC, pc_d=RESET_PC, fetch_valid=0, halted=0, fault=0.
//  States:
//   BOOT->RUN unconditionally.
//   RUN->HALTED on halt or fault condition.
//   HALTED holds until rst.
//  Addressing: read_instruct_addr = stall ? pc_d : pc.
//   Replaying pc_d keeps the memory output stable while stalled.
//  Memory latency is 1 cycle: the word addressed in cycle n appears in n+1.
//   Each edge: pc_d <= read_instruct_addr.
//  Redirect target (computed from pc_d; 32-bit, wrap modulo 2^32), priority jr > jump > branch:
//   jr:     jr_target
//   jump:   {pc_plus4_d[31:28], jump_index, 2'b00}
//   branch: pc_plus4_d + (sext(branch_offset) << 2)
//  Redirect is honoured only when fetch_valid=1; ignored on bubbles.
//  RUN edge, per case:
//   Redirect (overrides stall): pc <= target; fetch_valid <= 0 (wrong-path word squashed).
//   Else stall: pc and fetch_valid hold.
//   Else: pc <= pc+4; fetch_valid <= 1.
//  Fault: a redirect target with target[1:0]!=0 or target>=IMEM_BYTES
//   sets fault=1 and enters HALTED; pc is not updated.
//  Sequential pc+4 reaching IMEM_BYTES is also a fault.
//  HALTED: pc and pc_d frozen; fetch_valid=0; halted=1; all inputs except rst ignored.
//  halt with simultaneous redirect: halt wins; no redirect.
//  rst mid-stall or mid-redirect: reset values win; first valid word is RESET_PC, 2 cycles after rst drops.
// TESTING
//  1. rst 2 cycles, release:
//     read_instruct_addr 0,4,8,...; fetch_valid rises 2 cycles after release; pc_d=0 on the first valid cycle.
//  2. Stall for 3 cycles while pc_d=8:
//     read_instruct_addr=8; instruction/pc_d/fetch_valid constant; resumes at 12 with no skipped or duplicated word.
//  3. branch_taken with offset=16'hFFFE while pc_d=20:
//     next cycle fetch_valid=0; following cycle pc_d=16, valid=1.
//  4. Simultaneous jr_en (target 40) and jump_en (index 3):
//     jr wins; pc_d=40 valid two cycles later.
//  5. jr_target=6 and, separately, jump to byte 256:
//     fault=1, halted=1, fetch_valid=0 next cycle; read_instruct_addr frozen.
//  6. Redirect asserted during a bubble (fetch_valid=0):
//     ignored, sequential fetch continues; halt during stall -> halted next cycle, cleared only by rst.

Source files
------------

// File: rtl/pc_fetch_unit.sv
// PC and fetch control for a registered-read instruction memory.
// Tracks the PC of each returned word, flags bubbles and resolves decode redirects.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned IMEM_BYTES = 256
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_stall,
  input  logic        i_halt,
  input  logic        i_branch_taken,
  input  logic [15:0] i_branch_offset,
  input  logic        i_jump_en,
  input  logic [25:0] i_jump_index,
  input  logic        i_jr_en,
  input  logic [31:0] i_jr_target,
  output logic [31:0] o_read_instruct_addr,
  output logic [31:0] o_pc_d,
  output logic [31:0] o_pc_plus4_d,
  output logic        o_fetch_valid,
  output logic        o_halted,
  output logic        o_fault
);

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    S_BOOT   = 2'd0,
    S_RUN    = 2'd1,
    S_HALTED = 2'd2
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [XLEN-1:0]   r_pc, w_pc_nxt;
  logic [XLEN-1:0]   r_pc_d, w_pc_d_nxt;
  logic [XLEN-1:0]   r_pc_plus4_d;
  logic              r_fetch_valid, w_fetch_valid_nxt;
  logic              r_halted, w_halted_nxt;
  logic              r_fault, w_fault_nxt;

  logic [XLEN-1:0]   w_read_addr;
  logic [XLEN-1:0]   w_pc_plus4;
  logic [XLEN-1:0]   w_branch_off;
  logic [XLEN-1:0]   w_target;
  logic              w_redirect;
  logic              w_target_bad;
  logic              w_seq_bad;

  // Replaying pc_d while stalled keeps the memory output stable.
  assign w_read_addr  = (r_state != S_HALTED && i_stall) ? r_pc_d : r_pc;
  assign w_pc_plus4   = r_pc + XLEN'(4);
  assign w_branch_off = {{14{i_branch_offset[15]}}, i_branch_offset, 2'b00};
  assign w_redirect   = r_fetch_valid & (i_jr_en | i_jump_en | i_branch_taken);
  assign w_target_bad = (w_target[1:0] != 2'b00) || (w_target >= XLEN'(IMEM_BYTES));
  assign w_seq_bad    = (w_pc_plus4 >= XLEN'(IMEM_BYTES));

  always_comb begin
    if (i_jr_en)        w_target = i_jr_target;
    else if (i_jump_en) w_target = {r_pc_plus4_d[31:28], i_jump_index, 2'b00};
    else                w_target = r_pc_plus4_d + w_branch_off;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= S_BOOT;
      r_pc          <= RESET_PC;
      r_pc_d        <= RESET_PC;
      r_pc_plus4_d  <= RESET_PC + XLEN'(4);
      r_fetch_valid <= 1'b0;
      r_halted      <= 1'b0;
      r_fault       <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_pc          <= w_pc_nxt;
      r_pc_d        <= w_pc_d_nxt;
      r_pc_plus4_d  <= w_pc_d_nxt + XLEN'(4);
      r_fetch_valid <= w_fetch_valid_nxt;
      r_halted      <= w_halted_nxt;
      r_fault       <= w_fault_nxt;
    end
  end

  always_comb begin
    w_state_nxt       = r_state;
    w_pc_nxt          = r_pc;
    w_pc_d_nxt        = w_read_addr;
    w_fetch_valid_nxt = r_fetch_valid;
    w_halted_nxt      = r_halted;
    w_fault_nxt       = r_fault;
    unique case (r_state)
      S_BOOT: begin
        w_state_nxt       = S_RUN;
        w_fetch_valid_nxt = 1'b0;
      end
      S_RUN: begin
        if (i_halt) begin
          w_state_nxt       = S_HALTED;
          w_fetch_valid_nxt = 1'b0;
          w_halted_nxt      = 1'b1;
        end else if (w_redirect) begin
          if (w_target_bad) begin
            w_state_nxt       = S_HALTED;
            w_fetch_valid_nxt = 1'b0;
            w_halted_nxt      = 1'b1;
            w_fault_nxt       = 1'b1;
          end else begin
            // Wrong-path word already in flight is squashed.
            w_pc_nxt          = w_target;
            w_fetch_valid_nxt = 1'b0;
          end
        end else if (!i_stall) begin
          if (w_seq_bad) begin
            w_state_nxt       = S_HALTED;
            w_fetch_valid_nxt = 1'b0;
            w_halted_nxt      = 1'b1;
            w_fault_nxt       = 1'b1;
          end else begin
            w_pc_nxt          = w_pc_plus4;
            w_fetch_valid_nxt = 1'b1;
          end
        end
      end
      S_HALTED: begin
        w_pc_d_nxt        = r_pc_d;
        w_fetch_valid_nxt = 1'b0;
        w_halted_nxt      = 1'b1;
      end
      default: begin
        w_state_nxt       = S_BOOT;
        w_fetch_valid_nxt = 1'b0;
      end
    endcase
  end

  assign o_read_instruct_addr = w_read_addr;
  assign o_pc_d               = r_pc_d;
  assign o_pc_plus4_d         = r_pc_plus4_d;
  assign o_fetch_valid        = r_fetch_valid;
  assign o_halted             = r_halted;
  assign o_fault              = r_fault;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: directed scenarios plus randomized traffic against a cycle model.
module tb_pc_fetch_unit;

  localparam logic [31:0] RESET_PC   = 32'h0000_0000;
  localparam int unsigned IMEM_BYTES = 256;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, stall, halt, br, je, jre;
  logic [15:0] bo;
  logic [25:0] ji;
  logic [31:0] jt;
  logic [31:0] o_addr, o_pc_d, o_pc4;
  logic        o_fv, o_halted, o_fault;

  pc_fetch_unit #(.RESET_PC(RESET_PC), .IMEM_BYTES(IMEM_BYTES)) dut (
    .i_clk(clk), .i_rst(rst), .i_stall(stall), .i_halt(halt),
    .i_branch_taken(br), .i_branch_offset(bo),
    .i_jump_en(je), .i_jump_index(ji),
    .i_jr_en(jre), .i_jr_target(jt),
    .o_read_instruct_addr(o_addr), .o_pc_d(o_pc_d), .o_pc_plus4_d(o_pc4),
    .o_fetch_valid(o_fv), .o_halted(o_halted), .o_fault(o_fault)
  );

  int n_cmp = 0;
  int n_fail = 0;

  // Reference model: mode 0 = booting, 1 = running, 2 = halted
  int          m_mode;
  logic [31:0] m_pc, m_pc_d;
  logic        m_fv, m_halted, m_fault;

  logic [98:0] dut_vec;
  assign dut_vec = {o_addr, o_pc_d, o_pc4, o_fv, o_halted, o_fault};

  function automatic logic [98:0] exp_vec();
    logic [31:0] a, p4;
    a  = (m_mode == 2) ? m_pc : (stall ? m_pc_d : m_pc);
    p4 = m_pc_d + 32'd4;
    return {a, m_pc_d, p4, m_fv, m_halted, m_fault};
  endfunction

  task automatic clear_inputs();
    stall = 1'b0; halt = 1'b0; br = 1'b0; bo = 16'h0;
    je = 1'b0; ji = 26'h0; jre = 1'b0; jt = 32'h0;
  endtask

  task automatic go_halted(input logic flt);
    m_mode = 2; m_fv = 1'b0; m_halted = 1'b1;
    if (flt) m_fault = 1'b1;
  endtask

  // One clock: model consumes the inputs seen at the edge; outputs are sampled 1 time unit later.
  task automatic tick();
    logic [31:0] addr, p4, tgt, boff;
    logic        redir;
    @(posedge clk);
    addr  = (m_mode == 2) ? m_pc : (stall ? m_pc_d : m_pc);
    p4    = m_pc_d + 32'd4;
    boff  = {{14{bo[15]}}, bo, 2'b00};
    tgt   = jre ? jt : (je ? {p4[31:28], ji, 2'b00} : p4 + boff);
    redir = m_fv && (jre || je || br);
    if (rst) begin
      m_mode = 0; m_pc = RESET_PC; m_pc_d = RESET_PC;
      m_fv = 1'b0; m_halted = 1'b0; m_fault = 1'b0;
    end else if (m_mode == 0) begin
      m_mode = 1; m_pc_d = addr; m_fv = 1'b0;
    end else if (m_mode == 1) begin
      m_pc_d = addr;
      if (halt) go_halted(1'b0);
      else if (redir) begin
        if (tgt[1:0] != 2'b00 || tgt >= 32'(IMEM_BYTES)) go_halted(1'b1);
        else begin m_pc = tgt; m_fv = 1'b0; end
      end else if (!stall) begin
        if (m_pc + 32'd4 >= 32'(IMEM_BYTES)) go_halted(1'b1);
        else begin m_pc = m_pc + 32'd4; m_fv = 1'b1; end
      end
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; tick(); tick(); rst = 1'b0;
  endtask

  task automatic advance_to(input logic [31:0] target);
    bit hit = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (o_pc_d == target && o_fv) begin hit = 1'b1; break; end
      tick();
    end
    n_cmp++;
    if (!hit) begin
      n_fail++;
      $display("FAIL advance_timeout: got pc_d=%h fv=%b, wanted pc_d=%h valid", o_pc_d, o_fv, target);
    end
  endtask

  task automatic test_reset();
    clear_inputs();
    do_reset();
    n_cmp++;
    if ({o_fv, o_halted, o_fault, o_pc_d} !== {3'b000, RESET_PC}) begin
      n_fail++; $display("FAIL reset_values: got fv/h/f/pc_d=%b%b%b/%h", o_fv, o_halted, o_fault, o_pc_d);
    end
    tick();
    n_cmp++;
    if (o_fv !== 1'b0) begin n_fail++; $display("FAIL boot_bubble: got fv=%b want 0", o_fv); end
    tick();
    n_cmp++;
    if ({o_fv, o_pc_d} !== {1'b1, RESET_PC}) begin
      n_fail++; $display("FAIL first_valid: got fv=%b pc_d=%h want 1/%h", o_fv, o_pc_d, RESET_PC);
    end
    for (int k = 0; k < 2; k++) begin
      n_cmp++;
      if ({o_addr, o_pc_d} !== {RESET_PC + 32'(4 * (k + 1)), RESET_PC + 32'(4 * k)}) begin
        n_fail++; $display("FAIL seq_addr: got addr=%h pc_d=%h at step %0d", o_addr, o_pc_d, k);
      end
      tick();
    end
  endtask

  task automatic test_stall();
    advance_to(32'd8);
    stall = 1'b1; #1;
    n_cmp++;
    if (o_addr !== 32'd8) begin n_fail++; $display("FAIL stall_addr: got %h want 8", o_addr); end
    for (int k = 0; k < 3; k++) begin
      tick();
      n_cmp++;
      if ({o_addr, o_pc_d, o_fv} !== {32'd8, 32'd8, 1'b1}) begin
        n_fail++; $display("FAIL stall_hold: got addr=%h pc_d=%h fv=%b", o_addr, o_pc_d, o_fv);
      end
    end
    stall = 1'b0; #1;
    n_cmp++;
    if (o_addr !== 32'd12) begin n_fail++; $display("FAIL stall_resume_addr: got %h want c", o_addr); end
    tick();
    n_cmp++;
    if ({o_pc_d, o_fv} !== {32'd12, 1'b1} || dut_vec !== exp_vec()) begin
      n_fail++; $display("FAIL stall_resume: got %h exp %h", dut_vec, exp_vec());
    end
  endtask

  task automatic test_branch();
    advance_to(32'd20);
    br = 1'b1; bo = 16'hFFFE;
    tick();
    clear_inputs();
    n_cmp++;
    if (o_fv !== 1'b0 || dut_vec !== exp_vec()) begin
      n_fail++; $display("FAIL branch_bubble: got %h exp %h", dut_vec, exp_vec());
    end
    tick();
    n_cmp++;
    if ({o_pc_d, o_fv} !== {32'd16, 1'b1}) begin
      n_fail++; $display("FAIL branch_target: got pc_d=%h fv=%b want 10/1", o_pc_d, o_fv);
    end
  endtask

  task automatic test_jr_priority();
    advance_to(32'd24);
    jre = 1'b1; jt = 32'd40; je = 1'b1; ji = 26'd3;
    tick();
    clear_inputs();
    n_cmp++;
    if (o_fv !== 1'b0) begin n_fail++; $display("FAIL jr_bubble: got fv=%b want 0", o_fv); end
    tick();
    n_cmp++;
    if ({o_pc_d, o_fv} !== {32'd40, 1'b1}) begin
      n_fail++; $display("FAIL jr_priority: got pc_d=%h fv=%b want 28/1", o_pc_d, o_fv);
    end
  endtask

  task automatic test_fault(input bit use_jump);
    logic [31:0] frozen;
    if (use_jump) begin
      do_reset(); tick(); tick();
      je = 1'b1; ji = 26'd64;
    end else begin
      advance_to(32'd44);
      jre = 1'b1; jt = 32'd6;
    end
    tick();
    clear_inputs();
    n_cmp++;
    if ({o_fault, o_halted, o_fv} !== 3'b110) begin
      n_fail++; $display("FAIL fault_entry(jump=%0d): got f/h/fv=%b%b%b want 110", use_jump, o_fault, o_halted, o_fv);
    end
    frozen = o_addr;
    for (int k = 0; k < 3; k++) begin
      stall = 1'($urandom_range(0, 1)); br = 1'b1; jre = 1'b1; jt = 32'd8;
      tick();
      n_cmp++;
      if (o_addr !== frozen || dut_vec !== exp_vec()) begin
        n_fail++; $display("FAIL fault_frozen: got %h exp %h", dut_vec, exp_vec());
      end
    end
    clear_inputs();
  endtask

  task automatic test_bubble_and_halt();
    clear_inputs();
    do_reset();
    tick();
    jre = 1'b1; jt = 32'd100;
    tick();
    clear_inputs();
    n_cmp++;
    if ({o_pc_d, o_fv} !== {32'd0, 1'b1}) begin
      n_fail++; $display("FAIL bubble_redirect: got pc_d=%h fv=%b want 0/1", o_pc_d, o_fv);
    end
    tick();
    n_cmp++;
    if (o_pc_d !== 32'd4) begin n_fail++; $display("FAIL bubble_seq: got pc_d=%h want 4", o_pc_d); end
    stall = 1'b1; halt = 1'b1;
    tick();
    clear_inputs();
    n_cmp++;
    if ({o_halted, o_fv, o_fault} !== 3'b100) begin
      n_fail++; $display("FAIL halt_stall: got h/fv/f=%b%b%b want 100", o_halted, o_fv, o_fault);
    end
    repeat (3) tick();
    n_cmp++;
    if (o_halted !== 1'b1 || dut_vec !== exp_vec()) begin
      n_fail++; $display("FAIL halt_sticky: got %h exp %h", dut_vec, exp_vec());
    end
    rst = 1'b1; tick(); rst = 1'b0;
    n_cmp++;
    if (o_halted !== 1'b0) begin n_fail++; $display("FAIL halt_clear: got halted=%b want 0", o_halted); end
  endtask

  task automatic test_random();
    clear_inputs();
    do_reset();
    for (int c = 0; c < 600; c++) begin
      rst   = ($urandom_range(0, 79) == 0) || (o_halted && $urandom_range(0, 7) == 0);
      stall = ($urandom_range(0, 3) == 0);
      halt  = ($urandom_range(0, 199) == 0);
      br    = ($urandom_range(0, 11) == 0);
      bo    = 16'($urandom_range(0, 20)) - 16'd10;
      je    = ($urandom_range(0, 15) == 0);
      ji    = 26'($urandom_range(0, 70));
      jre   = ($urandom_range(0, 15) == 0);
      jt    = ($urandom_range(0, 9) == 0) ? 32'($urandom_range(0, 300)) : 32'($urandom_range(0, 63) * 4);
      #1;
      n_cmp++;
      if (dut_vec !== exp_vec()) begin
        n_fail++; $display("FAIL random_pre(c=%0d): got %h exp %h", c, dut_vec, exp_vec());
      end
      tick();
      n_cmp++;
      if (dut_vec !== exp_vec()) begin
        n_fail++; $display("FAIL random_post(c=%0d): got %h exp %h", c, dut_vec, exp_vec());
      end
    end
    clear_inputs();
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    m_mode = 0; m_pc = RESET_PC; m_pc_d = RESET_PC;
    m_fv = 1'b0; m_halted = 1'b0; m_fault = 1'b0;
    test_reset();
    test_stall();
    test_branch();
    test_jr_priority();
    test_fault(1'b0);
    test_fault(1'b1);
    test_bubble_and_halt();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
